// File: rtl/scr1_pipe_pkg.sv
// Pipeline-local types: the MUL/DIV request FSM states and the width of
// the optional MUL/DIV watchdog counter (enough for a limit of 1023).
package scr1_pipe_pkg;

  typedef enum logic [1:0] {
    SCR1_RVM_FSM_IDLE  = 2'd0,  // nothing in flight, ready for a new op
    SCR1_RVM_FSM_BUSY  = 2'd1,  // command presented to the IALU
    SCR1_RVM_FSM_DRAIN = 2'd2,  // op killed, waiting for the IALU to finish
    SCR1_RVM_FSM_WB    = 2'd3   // result held until writeback accepts it
  } type_scr1_rvm_req_fsm_e;

  localparam int unsigned SCR1_RVM_WDT_CNT_W = 10;

endpackage : scr1_pipe_pkg

// File: rtl/scr1_riscv_isa_decoding_pkg.sv
// Architectural constants and the IALU command encoding shared by the
// decode, execute and IALU stages.
package scr1_riscv_isa_decoding_pkg;

  localparam int unsigned SCR1_XLEN = 32;

  // IALU command select; the RVM subset starts at SCR1_IALU_CMD_MUL.
  typedef enum logic [4:0] {
    SCR1_IALU_CMD_NONE,
    SCR1_IALU_CMD_AND,
    SCR1_IALU_CMD_OR,
    SCR1_IALU_CMD_XOR,
    SCR1_IALU_CMD_ADD,
    SCR1_IALU_CMD_SUB,
    SCR1_IALU_CMD_SUB_LT,
    SCR1_IALU_CMD_SUB_LTU,
    SCR1_IALU_CMD_SUB_EQ,
    SCR1_IALU_CMD_SUB_NE,
    SCR1_IALU_CMD_SUB_GE,
    SCR1_IALU_CMD_SUB_GEU,
    SCR1_IALU_CMD_SLL,
    SCR1_IALU_CMD_SRL,
    SCR1_IALU_CMD_SRA,
    SCR1_IALU_CMD_MUL,
    SCR1_IALU_CMD_MULHU,
    SCR1_IALU_CMD_MULHSU,
    SCR1_IALU_CMD_MULH,
    SCR1_IALU_CMD_DIV,
    SCR1_IALU_CMD_DIVU,
    SCR1_IALU_CMD_REM,
    SCR1_IALU_CMD_REMU
  } type_scr1_ialu_cmd_sel_e;

endpackage : scr1_riscv_isa_decoding_pkg

// File: rtl/scr1_pipe_rvm_req_if.sv
// Handshake bundle around the MUL/DIV request stage: decode request,
// IALU command/result and writeback. slave = request stage, master = its
// surroundings (decode, IALU and writeback, or a testbench).
interface scr1_pipe_rvm_req_if;
  import scr1_riscv_isa_decoding_pkg::*;

  // decode -> request stage
  logic                    req_vd_i;
  logic                    req_rdy_o;
  type_scr1_ialu_cmd_sel_e req_cmd_i;
  logic [SCR1_XLEN-1:0]    req_op1_i;
  logic [SCR1_XLEN-1:0]    req_op2_i;
  logic [4:0]              req_rd_addr_i;

  // request stage <-> IALU
  logic                    exu2ialu_rvm_cmd_vd_o;
  type_scr1_ialu_cmd_sel_e exu2ialu_cmd_o;
  logic [SCR1_XLEN-1:0]    exu2ialu_main_op1_o;
  logic [SCR1_XLEN-1:0]    exu2ialu_main_op2_o;
  logic                    ialu2exu_rvm_res_rdy_i;
  logic [SCR1_XLEN-1:0]    ialu2exu_main_res_i;

  // request stage -> writeback
  logic                    wb_vd_o;
  logic                    wb_rdy_i;
  logic [SCR1_XLEN-1:0]    wb_data_o;
  logic [4:0]              wb_rd_addr_o;

  modport slave (
    input  req_vd_i, req_cmd_i, req_op1_i, req_op2_i, req_rd_addr_i,
    output req_rdy_o,
    output exu2ialu_rvm_cmd_vd_o, exu2ialu_cmd_o, exu2ialu_main_op1_o, exu2ialu_main_op2_o,
    input  ialu2exu_rvm_res_rdy_i, ialu2exu_main_res_i,
    output wb_vd_o, wb_data_o, wb_rd_addr_o,
    input  wb_rdy_i
  );

  modport master (
    output req_vd_i, req_cmd_i, req_op1_i, req_op2_i, req_rd_addr_i,
    input  req_rdy_o,
    input  exu2ialu_rvm_cmd_vd_o, exu2ialu_cmd_o, exu2ialu_main_op1_o, exu2ialu_main_op2_o,
    output ialu2exu_rvm_res_rdy_i, ialu2exu_main_res_i,
    input  wb_vd_o, wb_data_o, wb_rd_addr_o,
    output wb_rdy_i
  );

endinterface : scr1_pipe_rvm_req_if

// File: rtl/scr1_pipe_rvm_wdt.sv
// MUL/DIV watchdog: counts enabled cycles since the last clear and flags
// expiry on the LIMIT-th enabled cycle. Only part of the build when
// SCR1_RVM_WDT_EN is defined, so the default build carries no counter.
`ifdef SCR1_RVM_WDT_EN
module scr1_pipe_rvm_wdt
  import scr1_pipe_pkg::*;
#(
  parameter int unsigned LIMIT = 64  // 2..1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,     // a new op enters BUSY
  input  logic en_i,      // an op is in flight (BUSY or DRAIN)
  output logic expire_o   // this is the LIMIT-th in-flight cycle
);

  localparam logic [SCR1_RVM_WDT_CNT_W-1:0] EXPIRE_AT = SCR1_RVM_WDT_CNT_W'(LIMIT - 1);

  logic [SCR1_RVM_WDT_CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == EXPIRE_AT);

  // Next count: clear on entry, otherwise advance while in flight.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : scr1_pipe_rvm_wdt
`endif

// File: rtl/scr1_pipe_rvm_req.sv
// MUL/DIV request stage: accepts one RVM op from decode, holds it on the
// IALU command port until the IALU answers, then holds the result for
// writeback. A pipeline flush cannot abort the IALU, so a killed op is
// drained and its result dropped.
// Optional: define SCR1_RVM_WDT_EN to add a watchdog that abandons an op
// after SCR1_RVM_WDT_LIMIT in-flight cycles and raises rvm_timeout_o.
module scr1_pipe_rvm_req
  import scr1_riscv_isa_decoding_pkg::*;
  import scr1_pipe_pkg::*;
#(
  parameter int unsigned SCR1_RVM_WDT_LIMIT = 64  // 2..1023
) (
  input  logic                clk,
  input  logic                rst_n,
  scr1_pipe_rvm_req_if.slave  rvm,
  input  logic                exu_flush_i,
  output logic                rvm_timeout_o
);

  type_scr1_rvm_req_fsm_e  state_q, state_d;
  type_scr1_ialu_cmd_sel_e cmd_q, cmd_d;
  logic [SCR1_XLEN-1:0]    op1_q, op1_d;
  logic [SCR1_XLEN-1:0]    op2_q, op2_d;
  logic [SCR1_XLEN-1:0]    res_q, res_d;
  logic [4:0]              rd_q, rd_d;

  logic req_rdy;
  logic req_accept;
  logic res_take;
  logic in_flight;
  logic wdt_expire;

  // Ready when empty, or when the held result leaves this cycle; never
  // while the pipeline is being flushed.
  assign req_rdy    = !exu_flush_i &&
                      ((state_q == SCR1_RVM_FSM_IDLE) ||
                       ((state_q == SCR1_RVM_FSM_WB) && rvm.wb_rdy_i));
  assign req_accept = rvm.req_vd_i && req_rdy;
  assign in_flight  = (state_q == SCR1_RVM_FSM_BUSY) || (state_q == SCR1_RVM_FSM_DRAIN);
  assign res_take   = (state_q == SCR1_RVM_FSM_BUSY) && rvm.ialu2exu_rvm_res_rdy_i && !exu_flush_i;

`ifdef SCR1_RVM_WDT_EN
  logic wdt_fire;
  logic timeout_q, timeout_d;

  scr1_pipe_rvm_wdt #(
    .LIMIT (SCR1_RVM_WDT_LIMIT)
  ) i_wdt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (req_accept),
    .en_i     (in_flight),
    .expire_o (wdt_expire)
  );

  // Expiry only counts if nothing of higher priority ends the op this cycle.
  assign wdt_fire = wdt_expire && !rvm.ialu2exu_rvm_res_rdy_i &&
                    !((state_q == SCR1_RVM_FSM_BUSY) && exu_flush_i);

  // Sticky timeout flag: set on expiry, cleared by the next flush.
  always_comb begin
    timeout_d = timeout_q;
    if (wdt_fire) begin
      timeout_d = 1'b1;
    end else if (exu_flush_i) begin
      timeout_d = 1'b0;
    end
  end

  // Timeout flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign rvm_timeout_o = timeout_q;
`else
  assign wdt_expire    = 1'b0;
  assign rvm_timeout_o = 1'b0;
`endif

  // Next-state logic: flush outranks the result, the result outranks expiry.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      SCR1_RVM_FSM_IDLE: begin
        if (req_accept) state_d = SCR1_RVM_FSM_BUSY;
      end
      SCR1_RVM_FSM_BUSY: begin
        if (exu_flush_i) begin
          state_d = rvm.ialu2exu_rvm_res_rdy_i ? SCR1_RVM_FSM_IDLE : SCR1_RVM_FSM_DRAIN;
        end else if (rvm.ialu2exu_rvm_res_rdy_i) begin
          state_d = SCR1_RVM_FSM_WB;
        end else if (wdt_expire) begin
          state_d = SCR1_RVM_FSM_IDLE;
        end
      end
      SCR1_RVM_FSM_DRAIN: begin
        if (rvm.ialu2exu_rvm_res_rdy_i || wdt_expire) state_d = SCR1_RVM_FSM_IDLE;
      end
      SCR1_RVM_FSM_WB: begin
        if (exu_flush_i) begin
          state_d = SCR1_RVM_FSM_IDLE;
        end else if (rvm.wb_rdy_i) begin
          state_d = req_accept ? SCR1_RVM_FSM_BUSY : SCR1_RVM_FSM_IDLE;
        end
      end
      default: state_d = SCR1_RVM_FSM_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    if (!rst_n) begin
      state_q <= SCR1_RVM_FSM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch on accept, result capture on a live IALU answer.
  always_comb begin
    cmd_d = cmd_q;
    op1_d = op1_q;
    op2_d = op2_q;
    rd_d  = rd_q;
    res_d = res_q;
    if (req_accept) begin
      cmd_d = rvm.req_cmd_i;
      op1_d = rvm.req_op1_i;
      op2_d = rvm.req_op2_i;
      rd_d  = rvm.req_rd_addr_i;
    end
    if (res_take) begin
      res_d = rvm.ialu2exu_main_res_i;
    end
  end

  // Command/operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, because their outputs must read 0 after reset.
    if (!rst_n) begin
      cmd_q <= SCR1_IALU_CMD_NONE;
      op1_q <= '0;
      op2_q <= '0;
      rd_q  <= '0;
      res_q <= '0;
    end else begin
      cmd_q <= cmd_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      rd_q  <= rd_d;
      res_q <= res_d;
    end
  end

  assign rvm.req_rdy_o             = req_rdy;
  assign rvm.exu2ialu_rvm_cmd_vd_o = in_flight;
  assign rvm.exu2ialu_cmd_o        = cmd_q;
  assign rvm.exu2ialu_main_op1_o   = op1_q;
  assign rvm.exu2ialu_main_op2_o   = op2_q;
  assign rvm.wb_vd_o               = (state_q == SCR1_RVM_FSM_WB);
  assign rvm.wb_data_o             = res_q;
  assign rvm.wb_rd_addr_o          = rd_q;

endmodule : scr1_pipe_rvm_req

// File: tb/tb_scr1_pipe_rvm_req.sv
// Self-checking bench for scr1_pipe_rvm_req. The bench plays decode, IALU
// and writeback; every result it hands the DUT as the IALU answer is also
// pushed to a scoreboard and must come back out of the writeback port.
module tb_scr1_pipe_rvm_req;
  import scr1_riscv_isa_decoding_pkg::*;

  typedef struct {
    logic [SCR1_XLEN-1:0] data;
    logic [4:0]           rd;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic exu_flush_i = 1'b0;
  logic rvm_timeout_o;

  int errors = 0;
  int checks = 0;
  wb_exp_t sb[$];
  wb_exp_t exp_e;

  scr1_pipe_rvm_req_if rvm ();

  scr1_pipe_rvm_req #(
    .SCR1_RVM_WDT_LIMIT (64)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rvm           (rvm),
    .exu_flush_i   (exu_flush_i),
    .rvm_timeout_o (rvm_timeout_o)
  );

  always #5 clk = ~clk;

  // Scoreboard: every writeback handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rvm.wb_vd_o && rvm.wb_rdy_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got data=%h rd=%0d, required no writeback", rvm.wb_data_o, rvm.wb_rd_addr_o);
      end else begin
        exp_e = sb.pop_front();
        if (rvm.wb_data_o !== exp_e.data || rvm.wb_rd_addr_o !== exp_e.rd) begin
          errors++;
          $display("FAIL wb_data: got data=%h rd=%0d, required data=%h rd=%0d",
                   rvm.wb_data_o, rvm.wb_rd_addr_o, exp_e.data, exp_e.rd);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rvm.req_vd_i               = 1'b0;
    rvm.req_cmd_i              = SCR1_IALU_CMD_NONE;
    rvm.req_op1_i              = '0;
    rvm.req_op2_i              = '0;
    rvm.req_rd_addr_i          = '0;
    rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
    rvm.ialu2exu_main_res_i    = '0;
    rvm.wb_rdy_i               = 1'b0;
    exu_flush_i                = 1'b0;
  endtask

  task automatic offer(input type_scr1_ialu_cmd_sel_e cmd, input logic [SCR1_XLEN-1:0] op1,
                       input logic [SCR1_XLEN-1:0] op2, input logic [4:0] rd);
    rvm.req_vd_i      = 1'b1;
    rvm.req_cmd_i     = cmd;
    rvm.req_op1_i     = op1;
    rvm.req_op2_i     = op2;
    rvm.req_rd_addr_i = rd;
  endtask

  // One writeback-accept cycle; the scoreboard monitor does the comparison.
  task automatic drain_wb();
    rvm.wb_rdy_i = 1'b1;
    step();
    rvm.wb_rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o, rvm_timeout_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_valids: got cmd_vd/wb_vd/timeout=%b, required 000",
               {rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o, rvm_timeout_o});
    end
    checks++;
    if ({rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o, rvm.exu2ialu_main_op2_o,
         rvm.wb_data_o, rvm.wb_rd_addr_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got cmd=%0d op1=%h op2=%h data=%h rd=%0d, required all 0",
               rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o, rvm.exu2ialu_main_op2_o,
               rvm.wb_data_o, rvm.wb_rd_addr_o);
    end
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (rvm.req_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_rdy: got req_rdy=%b, required 1", rvm.req_rdy_o);
    end
    step();
  endtask

  // MUL 7*6 -> rd 5, IALU answers in cycle 4, writeback in cycle 5.
  task automatic test_basic();
    offer(SCR1_IALU_CMD_MUL, 32'd7, 32'd6, 5'd5);
    @(negedge clk);
    checks++;
    if (rvm.req_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: got req_rdy=%b, required 1", rvm.req_rdy_o);
    end
    step();
    rvm.req_vd_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
        rvm.ialu2exu_main_res_i    = 32'd42;
        sb.push_back('{data: 32'd42, rd: 5'd5});
      end
      @(negedge clk);
      checks++;
      if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b1 || rvm.exu2ialu_cmd_o !== SCR1_IALU_CMD_MUL ||
          rvm.exu2ialu_main_op1_o !== 32'd7 || rvm.exu2ialu_main_op2_o !== 32'd6 || rvm.wb_vd_o !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy c%0d: got cmd_vd=%b cmd=%0d op1=%0d op2=%0d wb_vd=%b, required 1 MUL 7 6 0",
                 c, rvm.exu2ialu_rvm_cmd_vd_o, rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o,
                 rvm.exu2ialu_main_op2_o, rvm.wb_vd_o);
      end
      step();
    end
    rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
    rvm.ialu2exu_main_res_i    = '0;
    @(negedge clk);
    checks++;
    if (rvm.wb_vd_o !== 1'b1 || rvm.wb_data_o !== 32'd42 || rvm.wb_rd_addr_o !== 5'd5 ||
        rvm.exu2ialu_rvm_cmd_vd_o !== 1'b0 || rvm.req_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_wb: got wb_vd=%b data=%0d rd=%0d cmd_vd=%b req_rdy=%b, required 1 42 5 0 0",
               rvm.wb_vd_o, rvm.wb_data_o, rvm.wb_rd_addr_o, rvm.exu2ialu_rvm_cmd_vd_o, rvm.req_rdy_o);
    end
    step();
    drain_wb();
    @(negedge clk);
    checks++;
    if (rvm.wb_vd_o !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL basic_done: got wb_vd=%b pending=%0d, required 0 0", rvm.wb_vd_o, sb.size());
    end
    step();
  endtask

  // Writeback stalls 3 cycles, then accepts while a new op is offered.
  task automatic test_wb_backpressure();
    offer(SCR1_IALU_CMD_MULHU, 32'h0000_1234, 32'h0000_0010, 5'd9);
    step();
    rvm.req_vd_i               = 1'b0;
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'hDEAD_0001;
    sb.push_back('{data: 32'hDEAD_0001, rd: 5'd9});
    step();
    rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
    rvm.ialu2exu_main_res_i    = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rvm.wb_vd_o !== 1'b1 || rvm.wb_data_o !== 32'hDEAD_0001 || rvm.wb_rd_addr_o !== 5'd9 ||
          rvm.req_rdy_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c%0d: got wb_vd=%b data=%h rd=%0d req_rdy=%b, required 1 dead0001 9 0",
                 c, rvm.wb_vd_o, rvm.wb_data_o, rvm.wb_rd_addr_o, rvm.req_rdy_o);
      end
      step();
    end
    rvm.wb_rdy_i = 1'b1;
    offer(SCR1_IALU_CMD_DIV, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    checks++;
    if (rvm.req_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_same_cycle_accept: got req_rdy=%b, required 1", rvm.req_rdy_o);
    end
    step();
    rvm.wb_rdy_i = 1'b0;
    rvm.req_vd_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b1 || rvm.exu2ialu_cmd_o !== SCR1_IALU_CMD_DIV ||
        rvm.exu2ialu_main_op1_o !== 32'd100 || rvm.exu2ialu_main_op2_o !== 32'd7 || rvm.wb_vd_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_cmd: got cmd_vd=%b cmd=%0d op1=%0d op2=%0d wb_vd=%b, required 1 DIV 100 7 0",
               rvm.exu2ialu_rvm_cmd_vd_o, rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o,
               rvm.exu2ialu_main_op2_o, rvm.wb_vd_o);
    end
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'd14;
    sb.push_back('{data: 32'd14, rd: 5'd3});
    step();
    rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
    drain_wb();
  endtask

  // Flush in BUSY cycle 2 -> DRAIN until res_rdy in cycle 6; flush in DRAIN ignored.
  task automatic test_flush_drain();
    offer(SCR1_IALU_CMD_MUL, 32'd3, 32'd3, 5'd1);
    step();
    rvm.req_vd_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      exu_flush_i                = (c == 2) || (c == 4);
      rvm.ialu2exu_rvm_res_rdy_i = (c == 6);
      rvm.ialu2exu_main_res_i    = 32'd9;
      @(negedge clk);
      checks++;
      if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b1 || rvm.wb_vd_o !== 1'b0 || (c >= 2 && rvm.req_rdy_o !== 1'b0)) begin
        errors++;
        $display("FAIL drain c%0d: got cmd_vd=%b wb_vd=%b req_rdy=%b, required 1 0 0",
                 c, rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o, rvm.req_rdy_o);
      end
      step();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rvm.req_rdy_o !== 1'b1 || rvm.exu2ialu_rvm_cmd_vd_o !== 1'b0 || rvm.wb_vd_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: got req_rdy=%b cmd_vd=%b wb_vd=%b, required 1 0 0",
               rvm.req_rdy_o, rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o);
    end
    step();
  endtask

  // Flush with res_rdy, flush in WB, and res_rdy while IDLE.
  task automatic test_flush_res();
    offer(SCR1_IALU_CMD_REM, 32'd50, 32'd8, 5'd4);
    step();
    rvm.req_vd_i = 1'b0;
    step();
    exu_flush_i                = 1'b1;
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'd77;
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rvm.req_rdy_o !== 1'b1 || rvm.exu2ialu_rvm_cmd_vd_o !== 1'b0 || rvm.wb_vd_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_res: got req_rdy=%b cmd_vd=%b wb_vd=%b, required 1 0 0",
               rvm.req_rdy_o, rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o);
    end
    offer(SCR1_IALU_CMD_MULH, 32'd2, 32'd2, 5'd6);
    step();
    rvm.req_vd_i               = 1'b0;
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'd88;
    step();
    rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
    exu_flush_i                = 1'b1;
    @(negedge clk);
    checks++;
    if (rvm.wb_vd_o !== 1'b1 || rvm.wb_data_o !== 32'd88 || rvm.req_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wb_pre: got wb_vd=%b data=%0d req_rdy=%b, required 1 88 0",
               rvm.wb_vd_o, rvm.wb_data_o, rvm.req_rdy_o);
    end
    step();
    exu_flush_i                = 1'b0;
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'd99;
    @(negedge clk);
    checks++;
    if (rvm.wb_vd_o !== 1'b0 || rvm.req_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_wb_post: got wb_vd=%b req_rdy=%b, required 0 1", rvm.wb_vd_o, rvm.req_rdy_o);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rvm.wb_vd_o !== 1'b0 || rvm.exu2ialu_rvm_cmd_vd_o !== 1'b0 || rvm.wb_data_o !== 32'd88) begin
      errors++;
      $display("FAIL idle_res_ignored: got wb_vd=%b cmd_vd=%b data=%0d, required 0 0 88",
               rvm.wb_vd_o, rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_data_o);
    end
    step();
  endtask

  // Eight ops with random latency and writeback stalls, chained through WB.
  task automatic test_back_to_back();
    type_scr1_ialu_cmd_sel_e cmds[8] = '{SCR1_IALU_CMD_MUL, SCR1_IALU_CMD_MULHU, SCR1_IALU_CMD_MULHSU,
                                         SCR1_IALU_CMD_MULH, SCR1_IALU_CMD_DIV, SCR1_IALU_CMD_DIVU,
                                         SCR1_IALU_CMD_REM, SCR1_IALU_CMD_REMU};
    logic [SCR1_XLEN-1:0] op1, op2, res;
    logic [4:0] rd;
    bit pending = 1'b0;
    for (int i = 0; i < 8; i++) begin
      op1 = $urandom();
      op2 = $urandom();
      rd  = 5'($urandom_range(1, 31));
      res = $urandom() | 32'h1;
      if (pending) begin
        for (int s = 0; s < int'($urandom_range(0, 2)); s++) step();
        rvm.wb_rdy_i = 1'b1;
      end
      offer(cmds[i], op1, op2, rd);
      @(negedge clk);
      checks++;
      if (rvm.req_rdy_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b_accept op%0d: got req_rdy=%b, required 1", i, rvm.req_rdy_o);
      end
      step();
      rvm.req_vd_i = 1'b0;
      rvm.wb_rdy_i = 1'b0;
      for (int l = 0; l <= int'($urandom_range(0, 3)); l++) begin
        @(negedge clk);
        checks++;
        if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b1 || rvm.exu2ialu_cmd_o !== cmds[i] ||
            rvm.exu2ialu_main_op1_o !== op1 || rvm.exu2ialu_main_op2_o !== op2) begin
          errors++;
          $display("FAIL b2b_cmd op%0d: got vd=%b cmd=%0d op1=%h op2=%h, required 1 %0d %h %h",
                   i, rvm.exu2ialu_rvm_cmd_vd_o, rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o,
                   rvm.exu2ialu_main_op2_o, cmds[i], op1, op2);
        end
        step();
      end
      rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
      rvm.ialu2exu_main_res_i    = res;
      sb.push_back('{data: res, rd: rd});
      step();
      rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
      pending = 1'b1;
    end
    drain_wb();
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || rvm.wb_vd_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drained: got pending=%0d wb_vd=%b, required 0 0", sb.size(), rvm.wb_vd_o);
    end
    step();
  endtask

  task automatic test_watchdog();
    offer(SCR1_IALU_CMD_DIVU, 32'd1, 32'd0, 5'd7);
    step();
    rvm.req_vd_i = 1'b0;
`ifdef SCR1_RVM_WDT_EN
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      checks++;
      if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b1 || rvm_timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL wdt_busy c%0d: got cmd_vd=%b timeout=%b, required 1 0", c, rvm.exu2ialu_rvm_cmd_vd_o, rvm_timeout_o);
      end
      step();
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b0 || rvm_timeout_o !== 1'b1 || rvm.req_rdy_o !== 1'b1) begin
        errors++;
        $display("FAIL wdt_expired c%0d: got cmd_vd=%b timeout=%b req_rdy=%b, required 0 1 1",
                 c, rvm.exu2ialu_rvm_cmd_vd_o, rvm_timeout_o, rvm.req_rdy_o);
      end
      step();
    end
    exu_flush_i = 1'b1;
    step();
    exu_flush_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rvm_timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL wdt_clear: got timeout=%b, required 0", rvm_timeout_o);
    end
    step();
`else
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      checks++;
      if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b1 || rvm_timeout_o !== 1'b0) begin
        errors++;
        $display("FAIL nowdt_busy c%0d: got cmd_vd=%b timeout=%b, required 1 0", c, rvm.exu2ialu_rvm_cmd_vd_o, rvm_timeout_o);
      end
      step();
    end
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'hCAFE_F00D;
    sb.push_back('{data: 32'hCAFE_F00D, rd: 5'd7});
    step();
    rvm.ialu2exu_rvm_res_rdy_i = 1'b0;
    drain_wb();
`endif
  endtask

  // Asynchronous reset mid-BUSY, then a stale IALU answer after release.
  task automatic test_async_reset();
    offer(SCR1_IALU_CMD_MUL, 32'h55, 32'hAA, 5'd12);
    step();
    rvm.req_vd_i = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o, rvm_timeout_o} !== 3'b000 ||
        {rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o, rvm.exu2ialu_main_op2_o,
         rvm.wb_data_o, rvm.wb_rd_addr_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: got cmd_vd=%b wb_vd=%b cmd=%0d op1=%h op2=%h data=%h rd=%0d, required all 0",
               rvm.exu2ialu_rvm_cmd_vd_o, rvm.wb_vd_o, rvm.exu2ialu_cmd_o, rvm.exu2ialu_main_op1_o,
               rvm.exu2ialu_main_op2_o, rvm.wb_data_o, rvm.wb_rd_addr_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    rvm.ialu2exu_rvm_res_rdy_i = 1'b1;
    rvm.ialu2exu_main_res_i    = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (rvm.exu2ialu_rvm_cmd_vd_o !== 1'b0) begin
      errors++;
      $display("FAIL async_release: got cmd_vd=%b, required 0", rvm.exu2ialu_rvm_cmd_vd_o);
    end
    step();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (rvm.wb_vd_o !== 1'b0 || rvm.req_rdy_o !== 1'b1 || rvm.wb_data_o !== '0) begin
      errors++;
      $display("FAIL async_late_res: got wb_vd=%b req_rdy=%b data=%h, required 0 1 0",
               rvm.wb_vd_o, rvm.req_rdy_o, rvm.wb_data_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wb_backpressure();
    test_flush_drain();
    test_flush_res();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL sim_timeout: got no completion by 200000, required completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule : tb_scr1_pipe_rvm_req

// File: doc/scr1_pipe_rvm_req.md
SCR1_PIPE_RVM_REQ -- requirements
Module: scr1_pipe_rvm_req

Interface
REQ-001 Parameter SCR1_RVM_WDT_LIMIT, default 64, SHALL set watchdog cycle limit (range 2..1023).
REQ-002 clk  in  1  core clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_vd_i  in  1  decode offers MUL/DIV op.
REQ-005 req_rdy_o  out  1  op accepted when req_vd_i && req_rdy_o.
REQ-006 req_cmd_i  in  type_scr1_ialu_cmd_sel_e  MUL/DIV command.
REQ-007 req_op1_i, req_op2_i  in  SCR1_XLEN each  operands.
REQ-008 req_rd_addr_i  in  5  destination register.
REQ-009 exu_flush_i  in  1  pipeline kill.
REQ-010 exu2ialu_rvm_cmd_vd_o  out  1  MUL/DIV command valid to IALU.
REQ-011 exu2ialu_cmd_o  out  type_scr1_ialu_cmd_sel_e; exu2ialu_main_op1_o, exu2ialu_main_op2_o  out  SCR1_XLEN  registered command/operands.
REQ-012 ialu2exu_rvm_res_rdy_i  in  1; ialu2exu_main_res_i  in  SCR1_XLEN  IALU result strobe/data.
REQ-013 wb_vd_o  out  1; wb_rdy_i  in  1; wb_data_o  out  SCR1_XLEN; wb_rd_addr_o  out  5  writeback handshake.
REQ-014 rvm_timeout_o  out  1  sticky watchdog error.

Function
REQ-015 FSM SHALL have states IDLE, BUSY, DRAIN, WB.
REQ-016 req_rdy_o SHALL be 1 in IDLE, and in WB when wb_rdy_i=1, and 0 whenever exu_flush_i=1.
REQ-017 Accept in cycle N SHALL latch cmd/ops/rd and assert exu2ialu_rvm_cmd_vd_o from cycle N+1 (state BUSY).
REQ-018 Command and operand outputs SHALL stay stable while exu2ialu_rvm_cmd_vd_o=1.
REQ-019 exu2ialu_rvm_cmd_vd_o SHALL be 1 in BUSY and DRAIN only, and drop the cycle after ialu2exu_rvm_res_rdy_i=1.
REQ-020 BUSY with res_rdy in cycle M SHALL capture ialu2exu_main_res_i and present wb_vd_o=1 from M+1 (state WB).
REQ-021 WB SHALL hold wb_data_o/wb_rd_addr_o/wb_vd_o until wb_rdy_i=1; then to BUSY if a new op is accepted same cycle, else IDLE.
REQ-022 Flush in BUSY without res_rdy SHALL move to DRAIN (IALU has no abort); DRAIN SHALL discard result on res_rdy and go IDLE.
REQ-023 Flush in BUSY coincident with res_rdy SHALL discard result and go IDLE; flush in WB SHALL drop wb_vd_o next cycle, go IDLE.
REQ-024 Flush in DRAIN or IDLE SHALL have no further effect; res_rdy outside BUSY/DRAIN SHALL be ignored.

Reset
REQ-025 Reset SHALL force IDLE; all valid outputs 0, data/cmd outputs 0, rvm_timeout_o 0, watchdog count 0, regardless of operation in flight.

Configuration
REQ-026 With SCR1_RVM_WDT_EN defined, a counter SHALL count cycles in BUSY/DRAIN, clear on entry; reaching SCR1_RVM_WDT_LIMIT without res_rdy SHALL drop cmd valid, go IDLE and set rvm_timeout_o until exu_flush_i or reset.
REQ-027 Without SCR1_RVM_WDT_EN, no counter SHALL exist and rvm_timeout_o SHALL be tied 0.

Structure
REQ-028 FSM enum type_scr1_rvm_req_fsm_e SHALL live in scr1_pipe_pkg; type_scr1_ialu_cmd_sel_e reused from scr1_riscv_isa_decoding_pkg.
REQ-029 Watchdog SHALL be sub-module scr1_pipe_rvm_wdt (clear, enable, expire), instantiated only under SCR1_RVM_WDT_EN.

Verification
REQ-030 Accept MUL op1=7 op2=6 rd=5 cycle 0, res_rdy+res=42 cycle 4 -> cmd_vd 1 cycles 1-4, wb_vd=1 data=42 rd=5 cycle 5.
REQ-031 wb_rdy_i=0 for 3 cycles then 1 with new req_vd -> wb outputs stable, new op accepted same cycle, cmd_vd next cycle.
REQ-032 Flush cycle 2 of BUSY, res_rdy cycle 6 -> cmd_vd held to cycle 6, wb_vd never asserted, req_rdy=1 cycle 7.
REQ-033 Flush and res_rdy same cycle -> no wb_vd, IDLE next cycle.
REQ-034 SCR1_RVM_WDT_EN, limit 64, no res_rdy -> cmd_vd drops after 64 BUSY cycles, rvm_timeout_o=1 until flush.
REQ-035 rst_n low during BUSY -> all outputs 0 asynchronously, late res_rdy after release ignored.
